// File: rtl/dcm_reset_seq_pkg.sv
// Shared clock/reset constants for the DCM reset sequencer: reset levels and FSM state encodings.
package dcm_reset_seq_pkg;

  localparam logic RESET_ENABLE  = 1'b1;
  localparam logic RESET_DISABLE = 1'b0;

  typedef enum logic [2:0] {
    ST_ASSERT = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  // Chip reset is released only while running; every other state holds it.
  function automatic logic chip_reset_of(state_e st);
    return (st == ST_RUN) ? RESET_DISABLE : RESET_ENABLE;
  endfunction

endpackage

// File: rtl/dcm_reset_seq_sync_2ff.sv
// Two-flop synchronizer for asynchronous status inputs; both stages reset to 0.
module dcm_reset_seq_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dcm_reset_seq.sv
// DCM supervisor: pulses the DCM reset, waits for lock with timeout/retry, and releases chip
// reset only after a stable lock window; drops chip reset again on lock loss or relock request.
module dcm_reset_seq
  import dcm_reset_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked_in,
  input  logic       relock_req,
  output logic       dcm_rst,
  output logic       chip_reset,
  output logic       running,
  output logic       fail,
  output logic [1:0] retry_cnt
);

  localparam logic [CNT_W-1:0] RstLast    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutMax = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       MaxRetry   = 2'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_d;
  logic             lock_s;
  logic             dcm_rst_d, chip_reset_d, running_d, fail_d;

  dcm_reset_seq_sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (locked_in),
    .q     (lock_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_cnt;
    // Saturate rather than wrap so a long stay never aliases a terminal count.
    cnt_d   = (cnt_q == TimeoutMax) ? cnt_q : cnt_q + CNT_W'(1);

    if (relock_req) begin
      state_d = ST_ASSERT;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          if (cnt_q == RstLast) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (lock_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TimeoutMax) begin
            if (retry_cnt < MaxRetry) begin
              retry_d = retry_cnt + 2'd1;
              state_d = ST_ASSERT;
            end else begin
              state_d = ST_FAIL;
            end
          end
        end
        ST_STABLE: begin
          if (!lock_s) state_d = ST_WAIT;
          else if (cnt_q == StableLast) state_d = ST_RUN;
        end
        ST_RUN: begin
          retry_d = '0;
          if (!lock_s) state_d = ST_ASSERT;
        end
        ST_FAIL: ;
        default: state_d = ST_ASSERT;
      endcase
    end

    // A relock restarts the count even when already in ASSERT.
    if (relock_req || (state_d != state_q)) cnt_d = '0;

    dcm_rst_d    = (state_d == ST_ASSERT) ? RESET_ENABLE : RESET_DISABLE;
    chip_reset_d = chip_reset_of(state_d);
    running_d    = (state_d == ST_RUN);
    fail_d       = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ASSERT;
      cnt_q      <= '0;
      retry_cnt  <= '0;
      dcm_rst    <= RESET_ENABLE;
      chip_reset <= RESET_ENABLE;
      running    <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_cnt  <= retry_d;
      dcm_rst    <= dcm_rst_d;
      chip_reset <= chip_reset_d;
      running    <= running_d;
      fail       <= fail_d;
    end
  end

endmodule

// File: tb/tb_dcm_reset_seq.sv
// Bench for dcm_reset_seq: directed sequence scenarios plus randomized lock/relock/reset traffic
// compared cycle by cycle against a phase-level reference model.
module tb_dcm_reset_seq;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 100;
  localparam int STABLE_CYCLES = 16;
  localparam int MAX_RETRY     = 3;

  localparam int M_ASSERT = 0;
  localparam int M_WAIT   = 1;
  localparam int M_STABLE = 2;
  localparam int M_RUN    = 3;
  localparam int M_FAIL   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       locked_in = 1'b0;
  logic       relock_req = 1'b0;
  logic       dcm_rst, chip_reset, running, fail;
  logic [1:0] retry_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Lock environment controls.
  bit dead        = 1'b0;
  int lock_delay  = 10;
  int glitch_req  = 0;
  int glitch_seen = 0;
  int since       = 0;

  // Reference model state.
  int m_ph = M_ASSERT;
  int m_el = 0;
  int m_rt = 0;
  bit m_s1 = 1'b0;
  bit m_s2 = 1'b0;

  dcm_reset_seq #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRY     (MAX_RETRY),
    .CNT_W         (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .locked_in  (locked_in),
    .relock_req (relock_req),
    .dcm_rst    (dcm_rst),
    .chip_reset (chip_reset),
    .running    (running),
    .fail       (fail),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // DCM stand-in: locks lock_delay cycles after its reset falls unless dead; glitches on request.
  always @(posedge clk) begin
    #2;
    if (dcm_rst) since = 0;
    else if (since < 1000000) since++;
    if (glitch_req != glitch_seen) begin
      glitch_seen = glitch_req;
      locked_in   = 1'b0;
    end else begin
      locked_in = !dead && (since > lock_delay);
    end
  end

  // Phase-level reference: time spent in each phase and the synchronizer delay line.
  always @(posedge clk) begin
    int nph;
    if (reset) begin
      m_ph = M_ASSERT; m_el = 0; m_rt = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      nph = m_ph;
      if (relock_req) begin
        nph  = M_ASSERT;
        m_rt = 0;
      end else begin
        case (m_ph)
          M_ASSERT: if (m_el + 1 >= RST_CYCLES) nph = M_WAIT;
          M_WAIT: begin
            if (m_s2) nph = M_STABLE;
            else if (m_el + 1 >= LOCK_TIMEOUT) begin
              if (m_rt < MAX_RETRY) begin
                m_rt++;
                nph = M_ASSERT;
              end else begin
                nph = M_FAIL;
              end
            end
          end
          M_STABLE: begin
            if (!m_s2) nph = M_WAIT;
            else if (m_el + 1 >= STABLE_CYCLES) nph = M_RUN;
          end
          M_RUN: begin
            m_rt = 0;
            if (!m_s2) nph = M_ASSERT;
          end
          default: ;
        endcase
      end
      m_el = (relock_req || nph != m_ph) ? 0 : m_el + 1;
      m_ph = nph;
      m_s2 = m_s1;
      m_s1 = locked_in;
    end
  end

  always @(negedge clk) begin
    logic [5:0] exp;
    if (chk_en) begin
      exp = {m_ph == M_ASSERT, m_ph != M_RUN, m_ph == M_RUN, m_ph == M_FAIL, 2'(m_rt)};
      check("outs", {26'd0, dcm_rst, chip_reset, running, fail, retry_cnt}, {26'd0, exp});
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits (bounded) at negedges until the selected output equals val; n = negedges waited.
  task automatic wait_sig(input int which, input logic val, input int limit, output int n);
    logic v;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      case (which)
        0: v = dcm_rst;
        1: v = chip_reset;
        2: v = running;
        default: v = fail;
      endcase
    end while (v !== val && n < limit);
  endtask

  initial begin
    int n, m, pulses;
    logic prev;

    do_reset();
    check("reset_outs", {26'd0, dcm_rst, chip_reset, running, fail, retry_cnt}, 32'h30);
    chk_en = 1'b1;

    // Nominal bring-up.
    wait_sig(0, 1'b0, 20, n);
    check("dcm_rst_width", n, 4);
    wait_sig(1, 1'b0, 100, m);
    check("chip_fall_time", n + m, 33);
    check("running", running, 1);

    // One-cycle lock loss in RUN.
    glitch_req++;
    wait_sig(1, 1'b1, 20, n);
    check("run_drop_lat", n, 4);
    check("relock_dcm_rise", dcm_rst, 1);
    wait_sig(0, 1'b0, 20, m);
    check("relock_pulse", m, 4);
    wait_sig(2, 1'b1, 100, n);
    check("relock_running", running, 1);
    check("relock_retry", retry_cnt, 0);

    // Glitch in STABLE at cnt=8 restarts the window.
    do_reset();
    repeat (21) @(negedge clk);
    glitch_req++;
    wait_sig(1, 1'b0, 100, m);
    check("stable_glitch_fall", 21 + m, 42);
    check("stable_glitch_retry", retry_cnt, 0);

    // Reset during WAIT_LOCK.
    do_reset();
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_wait", {26'd0, dcm_rst, chip_reset, running, fail, retry_cnt}, 32'h30);
    reset = 1'b0;
    wait_sig(0, 1'b0, 20, n);
    check("rst_in_wait_restart", n, 4);

    // Reset during RUN.
    wait_sig(2, 1'b1, 100, n);
    check("pre_rst_running", running, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_run", {26'd0, dcm_rst, chip_reset, running, fail, retry_cnt}, 32'h30);
    reset = 1'b0;
    wait_sig(0, 1'b0, 20, n);
    check("rst_in_run_restart", n, 4);

    // Dead DCM: exhaust retries.
    dead = 1'b1;
    do_reset();
    prev = 1'b1; pulses = 1; n = 0;
    while (fail !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
      if (dcm_rst && !prev) pulses++;
      prev = dcm_rst;
    end
    check("fail_time", n, 416);
    check("fail_pulses", pulses, 4);
    check("fail_retry", retry_cnt, 3);
    check("fail_chip_reset", chip_reset, 1);
    repeat (50) @(negedge clk);
    check("fail_sticky", {fail, dcm_rst, chip_reset}, 3'b101);

    // Relock out of FAIL with a working DCM.
    dead = 1'b0;
    relock_req = 1'b1;
    @(negedge clk);
    relock_req = 1'b0;
    check("relock_fail_clear", {fail, dcm_rst, retry_cnt}, 4'b0100);
    wait_sig(2, 1'b1, 100, n);
    check("relock_fail_run", {running, chip_reset}, 2'b10);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 399) == 0);
      relock_req = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 149) == 0) glitch_req++;
      if ($urandom_range(0, 599) == 0) dead = !dead;
      if (reset) lock_delay = int'($urandom_range(1, 30));
    end
    @(negedge clk);
    reset = 1'b0;
    relock_req = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
